axis_unalign: RTL and testbench
===============================

Name: axis_unalign

Overview:
- Inverse of the DMA realigner: takes a dense, lane-0-justified 32-bit AXI-Stream packet and re-emits it starting at an arbitrary byte offset within the first output beat.
- Typical use: the TX/write path, where packed payload must land at an unaligned destination address.
- Offset is supplied on s_tuser with the first beat of each packet.
- Byte ordering of each side is selectable (big/little endian).

Parameters:
- INPUT_BIG_ENDIAN, "FALSE", "TRUE": stream byte 0 is s_tdata[31:24] / s_tkeep[3]; "FALSE": s_tdata[7:0] / s_tkeep[0].
- OUTPUT_BIG_ENDIAN, "FALSE", same convention applied to m_tdata/m_tkeep.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_tdata  in  32  input data
- s_tkeep  in  4  input byte enables; contiguous from stream byte 0, all ones except on the last beat
- s_tlast  in  1  input end of packet
- s_tvalid  in  1  input valid
- s_tuser  in  2  leading empty lanes for the packet; sampled on the first beat only
- s_tready  out  1  input ready
- m_tdata  out  32  output data
- m_tkeep  out  4  output byte enables
- m_tlast  out  1  output end of packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready

Behaviour:
- Reset (async assert, sync-safe release): state=FIRST; m_tvalid=0; m_tdata=0; m_tkeep=0; m_tlast=0; hold register cleared; r=0.
- Internal order: both sides are converted to little-endian stream order by byte-reversing data and reversing keep when the side's parameter is "TRUE".
- Mapping: stream byte k of a packet with offset o goes to output beat floor((k+o)/4), lane (k+o) mod 4.
- Lanes without keep are driven 0 in m_tdata.
- Storage:
  - hold_data[23:0] and hold_keep[2:0] carry residual bytes in lanes 0..r-1.
  - r is in 0..3.
- Output register: one stage, latency 1 cycle from input accept to m_tvalid.
- Handshake: s_tready = (state!=FLUSH) && (!m_tvalid || m_tready). An output beat is held stable while m_tvalid && !m_tready.
- State FIRST (awaiting packet start), on accept:
  - r := s_tuser and hold_keep := 0, so the leading lanes are empty.
  - Then process the beat as STREAM.
- State STREAM, on accept of n bytes (n = popcount of s_tkeep):
  - Not last: emit {input bytes 0..3-r, hold lanes 0..r-1} with keep {4-r ones, hold_keep}. The new hold is input bytes 4-r..3, r unchanged. Stay in STREAM.
  - Last and r+n<=4: emit hold plus n bytes, keep = hold_keep | lanes r..r+n-1, m_tlast=1. Go to FIRST.
  - Last and r+n>4: emit a full 4-lane beat with m_tlast=0. The residual r+n-4 bytes go to hold. Go to FLUSH.
- State FLUSH:
  - s_tready=0.
  - When the output register is free, emit hold bytes in lanes 0..r'-1 with keep = ones(r'), m_tlast=1.
  - Go to FIRST.
- First-beat keep: the first output beat of a packet with o>0 has keep lanes 0..o-1 cleared.
- Single-beat packets:
  - A packet whose o+n<=4 produces exactly one beat.
  - Otherwise the packet produces exactly ceil((n_total+o)/4) beats.
- s_tuser on non-first beats is ignored.
- Protocol violations produce undefined output data but the FSM must still return to FIRST on s_tlast. Violations are:
  - non-contiguous s_tkeep;
  - s_tkeep=0;
  - partial s_tkeep on a non-last beat.
- areset asserted mid-packet: all state is discarded immediately and the next accepted beat is treated as a packet start.
- Simultaneous m_tready and new accept: the register is reloaded in the same cycle, giving full throughput of 1 beat/clk except for FLUSH bubbles.

Decomposition:
- Shared package axis_pkg holds:
  - LANES=4;
  - byte-reverse and keep-reverse functions;
  - keep-to-count and count-to-mask functions;
  - the state encoding (FIRST, STREAM, FLUSH).
- One natural sub-module: axis_lane_swap (combinational, parameterised enable). It is instantiated on the input and output sides for the endian conversion.

Test Plan:
- LE/LE, o=0, 0x33221100 keep 1111 last -> one beat 0x33221100 keep 1111 last, 1 cycle after accept.
- LE/LE, o=1, 0x33221100 keep 1111 last -> two beats, with s_tready low during the flush cycle:
  - beat 0x22110000 keep 1110 last=0;
  - beat 0x00000033 keep 0001 last=1.
- LE/LE, o=2, 0x33221100 keep 1111, then 0x00005544 keep 0011 last -> beats 0x11000000 keep 1100, then 0x55443322 keep 1111 last (no flush).
- BE in / LE out, o=2, 0x00112233 keep 1111 last -> 0x11000000 keep 1100, then 0x00003322 keep 0011 last.
- LE/LE, o=3, keep 0001 data 0xAB last -> single beat 0xAB000000 keep 1000 last. Then o=0 on the next packet -> first beat lanes are fully populated.
- Backpressure and reset:
  - With m_tready held low for 5 cycles mid-packet, m_tdata/m_tkeep/m_tlast stay stable and s_tready=0; the data sequence matches the no-stall run.
  - areset pulsed mid-packet -> m_tvalid=0 immediately and the next packet is aligned per its own s_tuser.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared types and byte/keep helpers for the axis_unalign datapath.
// Everything inside the core is kept in little-endian stream order, so stream byte 0 sits in lane 0.
package axis_pkg;
   localparam int LANES = 4;

   typedef enum logic [1:0] {FIRST, STREAM, FLUSH} state_t;

   function automatic logic [31:0] byte_rev(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [3:0] keep_rev(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   function automatic logic [2:0] keep_count(input logic [3:0] k);
      return {2'b0, k[0]} + {2'b0, k[1]} + {2'b0, k[2]} + {2'b0, k[3]};
   endfunction

   function automatic logic [3:0] count_mask(input logic [2:0] n);
      case (n)
         3'd0:    return 4'b0000;
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0011;
         3'd3:    return 4'b0111;
         default: return 4'b1111;
      endcase
   endfunction

   // Widen a lane-enable mask to a per-bit data mask.
   function automatic logic [31:0] keep_bytes(input logic [3:0] k);
      logic [31:0] m;
      for (int i = 0; i < LANES; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction
endpackage

// File: rtl/axis_unalign_if.sv
// Stream-in / stream-out bundle for axis_unalign.
// The slave modport is the unaligner's view; the master modport is the view of whatever surrounds it.
interface axis_unalign_if;
   import axis_pkg::*;

   logic [8*LANES-1:0] s_tdata;
   logic [LANES-1:0]   s_tkeep;
   logic               s_tlast;
   logic               s_tvalid;
   logic [1:0]         s_tuser;
   logic               s_tready;
   logic [8*LANES-1:0] m_tdata;
   logic [LANES-1:0]   m_tkeep;
   logic               m_tlast;
   logic               m_tvalid;
   logic               m_tready;

   modport master (
      output s_tdata, s_tkeep, s_tlast, s_tvalid, s_tuser, m_tready,
      input  s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
   );

   modport slave (
      input  s_tdata, s_tkeep, s_tlast, s_tvalid, s_tuser, m_tready,
      output s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
   );
endinterface

// File: rtl/axis_lane_swap.sv
// Optional byte-lane reversal.
// It converts one side of the stream between big-endian bus order and the core's little-endian order.
module axis_lane_swap
   import axis_pkg::*;
#(
   parameter bit ENABLE = 1'b0
) (
   input  logic [31:0] data_in,
   input  logic [3:0]  keep_in,
   output logic [31:0] data_out,
   output logic [3:0]  keep_out
);
   assign data_out = ENABLE ? byte_rev(data_in) : data_in;
   assign keep_out = ENABLE ? keep_rev(keep_in) : keep_in;
endmodule

// File: rtl/axis_unalign.sv
// Re-emits a dense, lane-0-justified packet starting at byte offset s_tuser within its first output beat.
//   state  | meaning
//   FIRST  | idle, next accepted beat starts a packet and loads the offset
//   STREAM | mid-packet, r residual bytes carried in the hold register
//   FLUSH  | input stalled, the leftover hold bytes go out as the last beat
module axis_unalign
   import axis_pkg::*;
#(
   parameter string INPUT_BIG_ENDIAN  = "FALSE",
   parameter string OUTPUT_BIG_ENDIAN = "FALSE"
) (
   input logic           aclk,
   input logic           areset,
   axis_unalign_if.slave axis
);
   localparam bit IN_BE  = (INPUT_BIG_ENDIAN == "TRUE");
   localparam bit OUT_BE = (OUTPUT_BIG_ENDIAN == "TRUE");

   logic [31:0] s_data_le, m_data_w;
   logic [3:0]  s_keep_le, m_keep_w;

   state_t      state_q, state_d;
   logic [23:0] hold_data_q, hold_data_d;
   logic [2:0]  hold_keep_q, hold_keep_d;
   logic [1:0]  r_q, r_d;
   logic [31:0] out_data_q, out_data_d;
   logic [3:0]  out_keep_q, out_keep_d;
   logic        out_last_q, out_last_d;
   logic        out_valid_q, out_valid_d;

   logic        out_free, s_ready, accept;
   logic [1:0]  r_eff;
   logic [23:0] hold_data_eff;
   logic [2:0]  hold_keep_eff;
   logic [55:0] cat_data;
   logic [6:0]  cat_keep;
   logic [3:0]  fill;
   logic [3:0]  flush_keep;

   axis_lane_swap #(.ENABLE(IN_BE)) u_swap_in (
      .data_in  (axis.s_tdata),
      .keep_in  (axis.s_tkeep),
      .data_out (s_data_le),
      .keep_out (s_keep_le)
   );

   axis_lane_swap #(.ENABLE(OUT_BE)) u_swap_out (
      .data_in  (out_data_q),
      .keep_in  (out_keep_q),
      .data_out (m_data_w),
      .keep_out (m_keep_w)
   );

   assign axis.m_tdata  = m_data_w;
   assign axis.m_tkeep  = m_keep_w;
   assign axis.m_tlast  = out_last_q;
   assign axis.m_tvalid = out_valid_q;
   assign axis.s_tready = s_ready;

   always_comb begin
      out_free      = !out_valid_q || axis.m_tready;
      s_ready       = (state_q != FLUSH) && out_free;
      accept        = s_ready && axis.s_tvalid;
      r_eff         = (state_q == FIRST) ? axis.s_tuser : r_q;
      hold_data_eff = (state_q == FIRST) ? 24'h0 : hold_data_q;
      hold_keep_eff = (state_q == FIRST) ? 3'b000 : hold_keep_q;
      // Input shifted up by r lanes, residual bytes slotted underneath: lanes 0..3 go out, 4..6 are carried.
      cat_data      = ({24'h0, s_data_le & keep_bytes(s_keep_le)} << {r_eff, 3'b000})
                    | {32'h0, hold_data_eff};
      cat_keep      = ({3'b000, s_keep_le} << r_eff) | {4'b0000, hold_keep_eff};
      fill          = {2'b00, r_eff} + {1'b0, keep_count(s_keep_le)};
      flush_keep    = count_mask({1'b0, r_q});

      state_d     = state_q;
      hold_data_d = hold_data_q;
      hold_keep_d = hold_keep_q;
      r_d         = r_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !axis.m_tready;

      if (state_q == FLUSH) begin
         if (out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = {8'h0, hold_data_q} & keep_bytes(flush_keep);
            out_keep_d  = flush_keep;
            out_last_d  = 1'b1;
            hold_data_d = 24'h0;
            hold_keep_d = 3'b000;
            r_d         = 2'd0;
            state_d     = FIRST;
         end
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = cat_data[31:0] & keep_bytes(cat_keep[3:0]);
         out_keep_d  = cat_keep[3:0];
         out_last_d  = 1'b0;
         hold_data_d = cat_data[55:32];
         hold_keep_d = cat_keep[6:4];
         r_d         = r_eff;
         state_d     = STREAM;
         if (axis.s_tlast) begin
            if (fill <= 4'd4) begin
               out_last_d  = 1'b1;
               hold_data_d = 24'h0;
               hold_keep_d = 3'b000;
               r_d         = 2'd0;
               state_d     = FIRST;
            end else begin
               r_d     = fill[1:0];
               state_d = FLUSH;
            end
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= FIRST;
         hold_data_q <= 24'h0;
         hold_keep_q <= 3'b000;
         r_q         <= 2'd0;
         out_data_q  <= 32'h0;
         out_keep_q  <= 4'b0000;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         hold_keep_q <= hold_keep_d;
         r_q         <= r_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_axis_unalign.sv
// Scoreboard bench for axis_unalign: three endian variants share one stimulus stream.
// Expected beats come from a byte-position model of each packet.
`timescale 1ns/1ps
module tb_axis_unalign;
   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic [31:0] st_data;
   logic [3:0]  st_keep;
   logic        st_last, st_valid;
   logic [1:0]  st_user;
   logic        m_rdy = 1'b0;
   int          rdy_mode = 1;

   int    n_checks = 0;
   int    n_fail = 0;
   beat_t exp_q[$];

   function automatic logic [31:0] swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [3:0] swapk(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

   axis_unalign_if if0 ();
   axis_unalign_if if1 ();
   axis_unalign_if if2 ();

   assign if0.s_tdata  = st_data;
   assign if0.s_tkeep  = st_keep;
   assign if1.s_tdata  = swap32(st_data);
   assign if1.s_tkeep  = swapk(st_keep);
   assign if2.s_tdata  = st_data;
   assign if2.s_tkeep  = st_keep;
   assign if0.s_tlast  = st_last;
   assign if1.s_tlast  = st_last;
   assign if2.s_tlast  = st_last;
   assign if0.s_tvalid = st_valid;
   assign if1.s_tvalid = st_valid;
   assign if2.s_tvalid = st_valid;
   assign if0.s_tuser  = st_user;
   assign if1.s_tuser  = st_user;
   assign if2.s_tuser  = st_user;
   assign if0.m_tready = m_rdy;
   assign if1.m_tready = m_rdy;
   assign if2.m_tready = m_rdy;

   axis_unalign #(.INPUT_BIG_ENDIAN("FALSE"), .OUTPUT_BIG_ENDIAN("FALSE")) dut0 (
      .aclk(aclk), .areset(areset), .axis(if0));
   axis_unalign #(.INPUT_BIG_ENDIAN("TRUE"), .OUTPUT_BIG_ENDIAN("FALSE")) dut1 (
      .aclk(aclk), .areset(areset), .axis(if1));
   axis_unalign #(.INPUT_BIG_ENDIAN("FALSE"), .OUTPUT_BIG_ENDIAN("TRUE")) dut2 (
      .aclk(aclk), .areset(areset), .axis(if2));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stream byte k lands at absolute position k+o; beat = pos/4, lane = pos%4.
   function automatic void push_expected(input bq_t b, input int o);
      int total;
      int nb;
      total = b.size() + o;
      nb = (total + 3) / 4;
      for (int i = 0; i < nb; i++) begin
         beat_t e;
         e.d = 32'h0;
         e.k = 4'h0;
         e.l = (i == nb - 1);
         for (int j = 0; j < 4; j++) begin
            int p;
            p = 4 * i + j;
            if (p >= o && p < total) begin
               e.d[8*j +: 8] = b[p - o];
               e.k[j] = 1'b1;
            end
         end
         exp_q.push_back(e);
      end
   endfunction

   always @(posedge aclk) begin
      #1;
      case (rdy_mode)
         0:       m_rdy = ($urandom_range(0, 9) < 7);
         1:       m_rdy = 1'b1;
         default: m_rdy = 1'b0;
      endcase
   end

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                            input logic [1:0] u);
      int  t;
      bit  done;
      t = 0;
      done = 0;
      st_data = d; st_keep = k; st_last = l; st_user = u; st_valid = 1'b1;
      while (!done && t < 2000) begin
         @(negedge aclk);
         if (if0.s_tready) done = 1;
         else t++;
         @(posedge aclk);
      end
      check("accept_wait", {63'h0, done}, 64'h1);
      #1;
      st_valid = 1'b0;
      st_data = $urandom;
      st_keep = 4'($urandom_range(0, 15));
      st_last = 1'($urandom_range(0, 1));
      st_user = 2'($urandom_range(0, 3));
   endtask

   task automatic send_pkt(input bq_t b, input int o, input bit gaps);
      int n;
      int nb;
      n = b.size();
      nb = (n + 3) / 4;
      push_expected(b, o);
      for (int i = 0; i < nb; i++) begin
         logic [31:0] d;
         logic [3:0]  k;
         d = $urandom;
         k = 4'h0;
         for (int j = 0; j < 4; j++) begin
            if (4 * i + j < n) begin
               d[8*j +: 8] = b[4*i + j];
               k[j] = 1'b1;
            end
         end
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) @(posedge aclk);
            if (g > 0) #1;
         end
         send_beat(d, k, (i == nb - 1), (i == 0) ? 2'(o) : 2'($urandom_range(0, 3)));
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || if0.m_tvalid) && t < 500) begin
         @(posedge aclk);
         #1;
         t++;
      end
   endtask

   logic [63:0] prev_out;
   bit          prev_stall = 0;
   always @(negedge aclk) begin
      beat_t       e;
      logic [63:0] cur;
      cur = {27'h0, if0.m_tlast, if0.m_tkeep, if0.m_tdata};
      if (areset) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) check("hold_stable", cur, prev_out);
         if (if0.m_tvalid && !if0.m_tready) check("stall_s_tready", {63'h0, if0.s_tready}, 64'h0);
         if (if0.m_tvalid && if0.m_tready) begin
            check("beat_expected", {63'h0, exp_q.size() != 0}, 64'h1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("beat_le_le", cur, {27'h0, e.l, e.k, e.d});
               check("beat_be_le", {27'h0, if1.m_tlast, if1.m_tkeep, if1.m_tdata},
                     {27'h0, e.l, e.k, e.d});
               check("beat_le_be", {27'h0, if2.m_tlast, swapk(if2.m_tkeep), swap32(if2.m_tdata)},
                     {27'h0, e.l, e.k, e.d});
            end
         end
         prev_stall = if0.m_tvalid && !if0.m_tready;
         prev_out = cur;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t b;
      st_valid = 1'b0; st_data = 32'h0; st_keep = 4'h0; st_last = 1'b0; st_user = 2'd0;
      rdy_mode = 1;
      areset = 1'b1;
      #2;
      check("rst_m_tvalid", {63'h0, if0.m_tvalid}, 64'h0);
      check("rst_m_tdata", {32'h0, if0.m_tdata}, 64'h0);
      check("rst_m_tkeep", {60'h0, if0.m_tkeep}, 64'h0);
      check("rst_m_tlast", {63'h0, if0.m_tlast}, 64'h0);
      check("rst_s_tready", {63'h0, if0.s_tready}, 64'h1);
      check("rst_m_tdata_be", {32'h0, if2.m_tdata}, 64'h0);
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk); #1;

      // o=0 single full beat, one-cycle latency
      b = '{8'h00, 8'h11, 8'h22, 8'h33};
      send_pkt(b, 0, 0);
      check("latency_1", {63'h0, if0.m_tvalid}, 64'h1);
      wait_drain();

      // o=1 full beat spills into a flush beat
      send_pkt(b, 1, 0);
      check("flush_s_tready", {63'h0, if0.s_tready}, 64'h0);
      wait_drain();

      // o=2, two input beats fit exactly into two output beats
      b = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      send_pkt(b, 2, 0);
      wait_drain();

      // o=2 single beat with flush (dut1 sees 0x00112233 big-endian)
      b = '{8'h00, 8'h11, 8'h22, 8'h33};
      send_pkt(b, 2, 0);
      wait_drain();

      // o=3 single byte, then o=0 follow-up
      b = '{8'hAB};
      send_pkt(b, 3, 0);
      b = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
      send_pkt(b, 0, 0);
      wait_drain();

      // backpressure mid-packet
      b = '{};
      for (int i = 0; i < 14; i++) b.push_back(8'($urandom));
      fork
         send_pkt(b, 1, 0);
         begin
            repeat (2) @(posedge aclk);
            @(negedge aclk) rdy_mode = 2;
            repeat (5) @(posedge aclk);
            @(negedge aclk) rdy_mode = 1;
         end
      join
      wait_drain();

      // areset mid-packet with a stalled output beat
      @(negedge aclk) rdy_mode = 2;
      @(posedge aclk); #1;
      send_beat(32'h33221100, 4'hf, 1'b0, 2'd1);
      st_data = 32'h77665544; st_keep = 4'hf; st_last = 1'b1; st_valid = 1'b1;
      #3 areset = 1'b1;
      #1;
      check("midrst_m_tvalid", {63'h0, if0.m_tvalid}, 64'h0);
      check("midrst_m_tvalid_be", {63'h0, if2.m_tvalid}, 64'h0);
      st_valid = 1'b0;
      exp_q.delete();
      @(posedge aclk);
      #3 areset = 1'b0;
      @(negedge aclk) rdy_mode = 1;
      @(posedge aclk); #1;
      b = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_pkt(b, 2, 0);
      wait_drain();

      // randomized traffic with random backpressure and gaps
      rdy_mode = 0;
      for (int p = 0; p < 250; p++) begin
         int len;
         len = $urandom_range(1, 13);
         b = '{};
         for (int i = 0; i < len; i++) b.push_back(8'($urandom));
         send_pkt(b, $urandom_range(0, 3), 1);
      end
      wait_drain();
      check("final_queue_empty", 64'(exp_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
